// File: rtl/databus_uart_tx.sv
// databus_uart_tx: captures CPU store words into a FIFO and serializes each
// word onto a UART TX line as eight 8N1 frames, least significant byte first.
// Handshake: a word is taken from databus on any rising edge with write=1
// unless the FIFO is full and no pop happens on that same edge, in which case
// it is dropped and overflow latches. There is no backpressure to the CPU.
module databus_uart_tx #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write,
  input  logic [63:0]              databus,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FSM state is kept as a named signal so checkers can bind to it.
  state_t        state;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [63:0]   shreg;
  logic          bit_done;
  logic          ready_load;
  logic          pop;
  logic          push;
  logic [CW-1:0] count_next;

  assign bit_done   = (bit_cnt == BW'(CLKS_PER_BIT - 1));
  // The transmitter can take a new word while idle, or on the very edge that
  // ends the last stop bit of a word, which gives gap-free back-to-back words.
  assign ready_load = (state == IDLE) ||
                      ((state == STOP) && bit_done && (byte_idx == 3'd7));
  assign pop        = !empty && ready_load;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push       = write && (!full || pop);

  // Next occupancy from the push/pop pair of this edge.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= databus;
  end

  // Pointers, occupancy, registered flags and the sticky overflow bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
      if (write && !push) overflow <= 1'b1;
    end
  end

  // Transmitter FSM with registered tx/busy; shreg shifts right once per data
  // bit so the current bit is always shreg[0] and the next byte lands in [7:0].
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            byte_idx <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (byte_idx != 3'd7) begin
              byte_idx <= byte_idx + 3'd1;
              tx       <= 1'b0;
              state    <= START;
            end else if (pop) begin
              shreg    <= mem[rd_ptr];
              byte_idx <= '0;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_databus_uart_tx.sv
// Bench for databus_uart_tx: directed writes push expected bytes into a
// queue; a UART receiver process decodes tx and pops/compares each byte.
module tb_databus_uart_tx;

  localparam int DEPTH = 8;
  localparam int CPB   = 4;
  localparam int WORD_CYC = 80 * CPB;

  logic        clock;
  logic        reset;
  logic        write;
  logic [63:0] databus;
  logic        tx;
  logic        busy;
  logic        full;
  logic        empty;
  logic [$clog2(DEPTH):0] count;
  logic        overflow;

  int tests  = 0;
  int failed = 0;

  logic [7:0] exp_q[$];

  databus_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .write(write), .databus(databus),
    .tx(tx), .busy(busy), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: present a word for exactly one rising edge.
  task automatic write_word(input logic [63:0] d, input bit accept);
    @(negedge clock);
    write   = 1'b1;
    databus = d;
    if (accept) for (int b = 0; b < 8; b++) exp_q.push_back(d[8*b +: 8]);
    @(posedge clock);
    #1 write = 1'b0;
  endtask

  // Called on the first negedge after the pop edge; measures the busy run
  // and checks the stop/start boundary between consecutive words.
  task automatic busy_run(input string name, input int exp_len);
    int j;
    j = 1;
    check({name, "_tx_start"}, tx, 1'b0);
    while (busy && j < 4000) begin
      if (j % WORD_CYC == 0 && j < exp_len) check({name, "_stop_end"}, tx, 1'b1);
      if (j % WORD_CYC == 1 && j > 1)      check({name, "_next_start"}, tx, 1'b0);
      @(negedge clock);
      j++;
    end
    check({name, "_busy_len"}, j - 1, exp_len);
    check({name, "_tx_idle"}, tx, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || !empty) && n < 6000) begin
      @(negedge clock);
      n++;
    end
    check("drain_done", {busy, empty}, 2'b01);
    repeat (4 * CPB) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Scoreboard monitor: mid-bit UART receiver on the falling edge.
  int         rx_ph;
  bit         rx_on = 1'b0;
  logic [7:0] rx_byte;
  logic [7:0] exp_b;
  always @(negedge clock) begin
    if (!reset) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_ph = 0;
      end
    end else begin
      rx_ph++;
      if (rx_ph == CPB / 2) check("rx_start_bit", tx, 1'b0);
      if (rx_ph >= CPB + CPB / 2 && rx_ph < 9 * CPB && (rx_ph % CPB) == CPB / 2)
        rx_byte[3'(rx_ph / CPB - 1)] = tx;
      if (rx_ph == 9 * CPB + CPB / 2) begin
        check("rx_stop_bit", tx, 1'b1);
        if (exp_q.size() == 0) begin
          check("rx_unexpected_byte", rx_byte, 9'h100);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_byte", rx_byte, exp_b);
        end
        rx_on = 1'b0;
      end
    end
  end

  initial begin
    write   = 1'b0;
    databus = '0;
    reset   = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("por_tx", tx, 1'b1);
    check("por_busy", busy, 1'b0);
    check("por_empty", empty, 1'b1);
    check("por_count", count, 0);
    check("por_overflow", overflow, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Asynchronous reset dropped mid-cycle
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single word: latency and word length
    write_word(64'h0000_0000_0000_00A5, 1'b1);
    @(negedge clock);
    check("single_pre_tx", tx, 1'b1);
    check("single_pre_count", count, 1);
    check("single_pre_empty", empty, 1'b0);
    @(negedge clock);
    check("single_busy_rise", busy, 1'b1);
    check("single_pop_empty", empty, 1'b1);
    busy_run("single", WORD_CYC);
    drain();

    // Back-to-back words, zero gap between them
    write_word(64'h0123_4567_89AB_CDEF, 1'b1);
    write_word(64'hFEDC_BA98_7654_3210, 1'b1);
    @(negedge clock);
    busy_run("b2b", 2 * WORD_CYC);
    drain();

    // Push plus pop while full on the byte-7 stop edge
    write_word(64'h1000_0000_0000_0001, 1'b1);
    for (int i = 2; i <= 9; i++) write_word(64'h1000_0000_0000_0000 | 64'(i), 1'b1);
    #2;
    check("pp_fill_count", count, 8);
    check("pp_fill_full", full, 1'b1);
    repeat (312) @(posedge clock);
    #2;
    check("pp_before_count", count, 8);
    write_word(64'h1000_0000_0000_000A, 1'b1);
    #2;
    check("pp_after_count", count, 8);
    check("pp_after_full", full, 1'b1);
    check("pp_after_overflow", overflow, 1'b0);
    drain();
    pulse_reset();
    repeat (2) @(negedge clock);

    // Overflow: ten words on consecutive edges
    write_word(64'h2000_0000_0000_0001, 1'b1);
    #2;
    check("ovf_w1_count", count, 1);
    write_word(64'h2000_0000_0000_0002, 1'b1);
    #2;
    check("ovf_w1_popped", count, 1);
    check("ovf_busy", busy, 1'b1);
    for (int i = 3; i <= 9; i++) write_word(64'h2000_0000_0000_0000 | 64'(i), 1'b1);
    #2;
    check("ovf_full_count", count, 8);
    check("ovf_full", full, 1'b1);
    check("ovf_not_yet", overflow, 1'b0);
    write_word(64'h2000_0000_0000_000A, 1'b0);
    #2;
    check("ovf_drop_count", count, 8);
    check("ovf_flag", overflow, 1'b1);
    drain();
    check("ovf_sticky", overflow, 1'b1);

    // Reset during DATA of byte 3, then a fresh word
    pulse_reset();
    repeat (2) @(negedge clock);
    write_word(64'h1122_3344_5566_7788, 1'b1);
    repeat (130) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_left", exp_q.size(), 5);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_count", count, 0);
    write_word(64'h0000_0000_0000_005A, 1'b1);
    @(negedge clock);
    @(negedge clock);
    busy_run("after_rst", WORD_CYC);
    drain();

    check("all_bytes_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/databus_uart_tx.md
# databus_uart_tx

Memory-mapped output stage sitting directly downstream of the CPU. It captures each 64-bit value the CPU drives on `Databus` while `Write` is asserted and buffers it in a small FIFO. It serializes each buffered word onto a UART TX line as eight 8N1 byte frames. This lets the bench and board observe store traffic without stalling the core.

## Interface
- `DEPTH`, 8: FIFO depth in 64-bit words; must be a power of two, at least 2.
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be at least 2.
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `write` in 1: CPU store strobe, connected to CPU `Write`.
- `databus` in 64: CPU store data, connected to CPU `Databus`.
- `tx` out 1: UART serial output; idles high.
- `busy` out 1: high while a frame is on `tx`.
- `full` out 1: FIFO holds `DEPTH` words.
- `empty` out 1: FIFO holds 0 words.
- `count` out $clog2(DEPTH)+1: number of words currently in the FIFO.
- `overflow` out 1: sticky flag set by a dropped write.

## Operation
- **Push.** On a rising edge where `write`=1, the word is accepted if `full`=0 or a pop occurs on the same edge.
  - An accepted word is written at the write pointer, and the write pointer increments modulo `DEPTH`.
  - If `write`=1 while `full`=1 and no pop occurs, the word is dropped and `overflow` is set to 1. `overflow` is cleared only by reset.
- **Pop.** A pop occurs on an edge where `empty`=0 and the transmitter is ready to load.
  - Ready to load means state IDLE, or the final stop bit of byte 7 completing.
  - The word at the read pointer is copied into a 64-bit shift register, and the read pointer increments modulo `DEPTH`.
- **Count.** `count` increments on push-only, decrements on pop-only, and is unchanged on push+pop. `full` = (`count`==`DEPTH`); `empty` = (`count`==0). All three are registered.
- **Transmitter FSM.** States are IDLE, START, DATA, STOP. A bit counter runs 0..`CLKS_PER_BIT`-1, a bit index runs 0..7, and a byte index runs 0..7.
  - IDLE: `tx`=1. On a pop, go to START with byte index 0.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = current byte bit, LSB first, `CLKS_PER_BIT` cycles per bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles.
    - If byte index is below 7, increment it and go to START.
    - If byte index is 7 and the FIFO is non-empty, pop and go to START (no idle gap).
    - Otherwise go to IDLE.
- **Byte order.** Little-endian: byte 0 = `databus[7:0]`, sent first; byte 7 = `databus[63:56]`, sent last.
- `busy` = 1 in START, DATA and STOP; 0 in IDLE.
- **Reset (`reset`=0) is asynchronous.**
  - Pointers and `count` go to 0; `empty`=1, `full`=0, `overflow`=0.
  - State goes to IDLE, `tx`=1, `busy`=0.
  - A partial frame is abandoned and FIFO contents are discarded. `tx` returns high immediately, not at the next edge.
  - Normal operation resumes on the first rising edge after `reset` returns to 1.

## Timing
- `tx` is registered; no combinational path from `write` or `databus` to `tx`.
- **Latency.** A word pushed into an empty FIFO on edge N is popped on edge N+1. `tx` falls and `busy` rises after edge N+1.
- **Frame length.**
  - One byte is 10·`CLKS_PER_BIT` cycles.
  - One word is 80·`CLKS_PER_BIT` cycles.
  - Consecutive bytes, and consecutive words with the FIFO non-empty, follow with zero gap.
- **Flags.** `count`, `full` and `empty` reflect a push or pop after the edge on which it occurs.
- **Throughput.** The CPU may assert `write` every cycle. Sustained input faster than one word per 80·`CLKS_PER_BIT` cycles fills the FIFO, and further words are then dropped per the push rule.

## Test plan
- **Reset.** Drop `reset` to 0 mid-cycle, not on an edge. Required: `tx`=1, `busy`=0, `empty`=1, `count`=0 and `overflow`=0 immediately, before the next edge.
- **Single word.** With `CLKS_PER_BIT`=4, write 64'h0000_0000_0000_00A5 at edge N.
  - `tx` falls after N+1.
  - Byte 0 data bits are 1,0,1,0,0,1,0,1, each 4 cycles.
  - Bytes 1-7 send 0x00.
  - `busy` falls exactly 320 cycles after N+1, with `tx`=1.
- **Overflow.** With `DEPTH`=8, write 10 words on consecutive edges. Required:
  - Word 1 popped immediately.
  - Words 2-9 fill the FIFO: `count`=8, `full`=1.
  - Word 10 dropped and `overflow`=1.
  - The serial output shows words 1-9 in order.
- **Back-to-back.** Write 64'h0123_4567_89AB_CDEF then 64'hFEDC_BA98_7654_3210. Required:
  - The start bit of the second word begins on the edge ending the final stop bit of the first word, with no idle cycle.
  - The byte order of the first word is EF, CD, AB, 89, 67, 45, 23, 01.
- **Push+pop when full.** Hold the FIFO full and assert `write` on the edge where the byte-7 stop bit ends. Required: the word is accepted, `count` stays 8, `overflow` stays 0.
- **Reset mid-frame.** Assert `reset` during DATA of byte 3. Required: `tx`=1 at once and the FIFO is empty after release. A new write 64'h5A then transmits normally, starting with byte 0x5A.
